// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display path.
// Holds the BCD converter FSM encoding and the power-of-ten helper.
package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SHIFT  = 2'd1;
  localparam state_t FINISH = 2'd2;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble correction cell.
// Adds 3 to a BCD digit of 5 or more ahead of the next shift.
module bcd_add3_cell
  import stopwatch_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);

  always_comb begin
    q = d;
    if (d >= BCD_W'(5)) begin
      q = d + BCD_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary to packed-BCD converter (shift-add-3).
// One bit per cycle; result held between conversions.
module bin_to_bcd_seq
  import stopwatch_pkg::*;
#(
  parameter int IN_W   = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                  overflow
);

  localparam int BW = BCD_W * DIGITS;
  localparam int CW = $clog2(IN_W + 1);
  localparam int LW = IN_W + BW;
  localparam logic [LW-1:0] LIMIT = LW'(pow10(DIGITS));

  state_t          state;
  state_t          nstate;
  logic [CW-1:0]   cnt;
  logic [IN_W-1:0] shreg;
  logic [BW-1:0]   scratch;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   shifted;
  logic            ovf_q;
  logic            accept;
  logic            last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .d (scratch[g*BCD_W +: BCD_W]),
      .q (adj[g*BCD_W +: BCD_W])
    );
  end

  // the top digit's carry-out falls off here: mod 10**DIGITS
  assign shifted = BW'({adj, shreg[IN_W-1]});
  assign accept  = (state == IDLE) && start;
  assign last    = (state == SHIFT) && (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (1'b1)
      state == IDLE:   if (start) nstate = SHIFT;
      state == SHIFT:  if (last) nstate = FINISH;
      state == FINISH: nstate = IDLE;
      default:         nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      shreg   <= '0;
      scratch <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      cnt     <= CW'(IN_W);
      shreg   <= bin;
      scratch <= '0;
      ovf_q   <= (LW'(bin) >= LIMIT);
    end else if (state == SHIFT) begin
      cnt     <= cnt - CW'(1);
      shreg   <= shreg << 1;
      scratch <= shifted;
    end
  end

  // outputs land on the edge into FINISH so they are valid with done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd      <= '0;
      overflow <= 1'b0;
    end else if (last) begin
      bcd      <= shifted;
      overflow <= ovf_q;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed scoreboard bench for bin_to_bcd_seq.
// Three instances cover (6,2), (6,1) and (16,5).
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [5:0]  bin_a = '0, bin_b = '0;
  logic [15:0] bin_c = '0;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [7:0]  bcd_a;
  logic [3:0]  bcd_b;
  logic [19:0] bcd_c;
  logic        ovf_a, ovf_b, ovf_c;

  int vec = 0;
  int errs = 0;
  int ndone_a = 0;
  logic [20:0] sbq[$];

  always #5 clk = ~clk;

  always @(negedge clk) if (done_a) ndone_a++;

  bin_to_bcd_seq #(.IN_W(6), .DIGITS(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
  );

  bin_to_bcd_seq #(.IN_W(6), .DIGITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
  );

  bin_to_bcd_seq #(.IN_W(16), .DIGITS(5)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic [15:0] b, input logic s);
    case (w)
      0: begin start_a = s; bin_a = b[5:0]; end
      1: begin start_b = s; bin_b = b[5:0]; end
      default: begin start_c = s; bin_c = b; end
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic get_ovf(input int w);
    case (w)
      0: return ovf_a;
      1: return ovf_b;
      default: return ovf_c;
    endcase
  endfunction

  function automatic logic [19:0] get_bcd(input int w);
    case (w)
      0: return {12'd0, bcd_a};
      1: return {16'd0, bcd_b};
      default: return bcd_c;
    endcase
  endfunction

  task automatic check_out(input string tag, input int w);
    logic [20:0] e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_bcd"}, 32'(get_bcd(w)), 32'(e[19:0]));
      chk({tag, "_ovf"}, 32'(get_ovf(w)), 32'(e[20]));
    end
  endtask

  // n counts ticks from the current cycle to the done cycle
  task automatic wait_done(input int w, output int n);
    n = 0;
    while (!get_done(w) && n < 40) begin
      tick();
      n++;
    end
  endtask

  // pulse: cycle offset from accept at which a stray start is raised
  task automatic conv(input string tag, input int w, input logic [15:0] b,
                      input logic [19:0] eb, input logic eo,
                      input int lat, input int pulse);
    int n;
    sbq.push_back({eo, eb});
    drive(w, b, 1'b1);
    tick();
    n = 0;
    while (!get_done(w) && n < 40) begin
      drive(w, b, (pulse > 0 && 1 + n == pulse));
      tick();
      n++;
    end
    drive(w, b, 1'b0);
    chk({tag, "_lat"}, 32'(1 + n), 32'(lat));
    check_out(tag, w);
    chk({tag, "_busy"}, 32'(get_busy(w)), 32'd0);
    tick();
  endtask

  initial begin
    int n;
    int d0;
    logic stable;

    #12;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_bcd", 32'(bcd_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    conv("a59", 0, 16'd59, 20'h59, 1'b0, 7, 0);
    conv("a0", 0, 16'd0, 20'h00, 1'b0, 7, 0);
    conv("a63", 0, 16'd63, 20'h63, 1'b0, 7, 0);
    conv("b47", 1, 16'd47, 20'h7, 1'b1, 7, 0);
    conv("b9", 1, 16'd9, 20'h9, 1'b0, 7, 0);

    d0 = ndone_a;
    conv("a59p", 0, 16'd59, 20'h59, 1'b0, 7, 3);
    repeat (10) tick();
    chk("a59p_ndone", 32'(ndone_a - d0), 32'd1);
    chk("a59p_idle", 32'(busy_a), 32'd0);

    sbq.push_back({1'b0, 20'h12});
    sbq.push_back({1'b0, 20'h34});
    drive(0, 16'd12, 1'b1);
    tick();
    drive(0, 16'd34, 1'b1);
    wait_done(0, n);
    chk("hold_lat1", 32'(n + 1), 32'd7);
    check_out("hold12", 0);
    tick();
    tick();
    drive(0, 16'd34, 1'b0);
    stable = 1'b1;
    n = 0;
    while (!done_a && n < 40) begin
      if (bcd_a !== 8'h12) stable = 1'b0;
      tick();
      n++;
    end
    chk("hold_gap", 32'(n + 2), 32'd8);
    chk("hold_stable", 32'(stable), 32'd1);
    check_out("hold34", 0);
    tick();

    d0 = ndone_a;
    drive(0, 16'd59, 1'b1);
    tick();
    drive(0, 16'd59, 1'b0);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    chk("abort_bcd", 32'(bcd_a), 32'd0);
    chk("abort_ovf", 32'(ovf_a), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("abort_ndone", 32'(ndone_a - d0), 32'd0);
    conv("a7", 0, 16'd7, 20'h07, 1'b0, 7, 0);

    conv("c65535", 2, 16'd65535, 20'h65535, 1'b0, 17, 0);
    conv("c1234", 2, 16'd1234, 20'h01234, 1'b0, 17, 0);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
